// File: rtl/match_event_counter_pkg.sv
// Shared definitions for the match event counter: FSM states, display
// select codes and the fixed statistics width.
package match_event_counter_pkg;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_COUNT0  = 2'b00,
    SEL_COUNT1  = 2'b01,
    SEL_MAX_RUN = 2'b10,
    SEL_RUN_LEN = 2'b11
  } sel_t;

  // Increment that sticks at the top code instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/match_event_counter_hex7seg.sv
// Hex nibble to active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: seg gets a value on every path (default plus full case), so no latch is inferred.
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/match_event_counter.sv
// Statistics collector behind a four-in-a-row sequence detector: counts
// zeros/ones matches, tracks the longest completed match and drives two hex digits.
module match_event_counter
  import match_event_counter_pkg::*;
(
  input  logic       Clock,
  input  logic       reset_n,
  input  logic       z,
  input  logic       run_type,
  input  logic       clr,
  input  logic [1:0] sel,
  output logic [7:0] count0,
  output logic [7:0] count1,
  output logic [7:0] max_run,
  output logic       match_pulse,
  output logic       ovf,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  state_t state, state_next;
  logic   z_d;
  cnt_t   run_len;
  cnt_t   disp;
  logic   rise;
  logic   start;
  logic   finish;

  assign rise   = z & ~z_d;
  assign start  = rise & (state == ST_IDLE);
  assign finish = (state == ST_RUN) & ~z;

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (rise) state_next = ST_RUN;
        ST_RUN:  if (!z)   state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // z_d keeps tracking z even under clr, so a level already high across a
  // clear never looks like a fresh match.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      z_d         <= 1'b0;
      count0      <= '0;
      count1      <= '0;
      max_run     <= '0;
      run_len     <= '0;
      match_pulse <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      z_d <= z;
      if (clr) begin
        count0      <= '0;
        count1      <= '0;
        max_run     <= '0;
        run_len     <= '0;
        match_pulse <= 1'b0;
        ovf         <= 1'b0;
      end else begin
        match_pulse <= start;
        if (start) begin
          run_len <= cnt_t'(1);
          if (run_type) begin
            count1 <= count1 + 1'b1;
            if (count1 == CNT_MAX) ovf <= 1'b1;
          end else begin
            count0 <= count0 + 1'b1;
            if (count0 == CNT_MAX) ovf <= 1'b1;
          end
        end else if (state == ST_RUN && z) begin
          run_len <= sat_inc(run_len);
        end
        if (finish && (run_len > max_run)) max_run <= run_len;
      end
    end
  end

  always_comb begin
    disp = count0;
    case (sel)
      SEL_COUNT0:  disp = count0;
      SEL_COUNT1:  disp = count1;
      SEL_MAX_RUN: disp = max_run;
      SEL_RUN_LEN: disp = run_len;
      default:     disp = count0;
    endcase
  end

  hex7seg u_hex1 (
    .nibble (disp[7:4]),
    .seg    (HEX1)
  );

  hex7seg u_hex0 (
    .nibble (disp[3:0]),
    .seg    (HEX0)
  );

endmodule

// File: tb/tb_match_event_counter.sv
// Scoreboard bench: stimulus pushes expected outputs from a timestamp-based
// run model; a monitor pops one entry after every clock edge and compares.
module tb_match_event_counter;

  logic       Clock = 1'b0;
  logic       reset_n;
  logic       z;
  logic       run_type;
  logic       clr;
  logic [1:0] sel;
  logic [7:0] count0, count1, max_run;
  logic       match_pulse, ovf;
  logic [6:0] HEX1, HEX0;

  match_event_counter dut (
    .Clock       (Clock),
    .reset_n     (reset_n),
    .z           (z),
    .run_type    (run_type),
    .clr         (clr),
    .sel         (sel),
    .count0      (count0),
    .count1      (count1),
    .max_run     (max_run),
    .match_pulse (match_pulse),
    .ovf         (ovf),
    .HEX1        (HEX1),
    .HEX0        (HEX0)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] mx;
    logic       pulse;
    logic       ovf;
    logic [6:0] h1;
    logic [6:0] h0;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulse_cnt = 0;

  // Model: matches as timestamps; lengths are differences of edge indices.
  int k = 0;
  int m_prev_z, m_active, m_start, m_n0, m_n1, m_best, m_len;
  bit m_ovf, m_pulse;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    logic [6:0] g;
    case (v)
      0: g = 7'h40;  1: g = 7'h79;  2: g = 7'h24;  3: g = 7'h30;
      4: g = 7'h19;  5: g = 7'h12;  6: g = 7'h02;  7: g = 7'h78;
      8: g = 7'h00;  9: g = 7'h10; 10: g = 7'h08; 11: g = 7'h03;
     12: g = 7'h46; 13: g = 7'h21; 14: g = 7'h06; default: g = 7'h0E;
    endcase
    return g;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_prev_z = 0; m_active = 0; m_start = 0;
    m_n0 = 0; m_n1 = 0; m_best = 0; m_len = 0;
    m_ovf = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic step(input logic zz, input logic rr, input logic cc, input logic [1:0] ss);
    bit   rise;
    int   len;
    int   v;
    exp_t e;
    @(negedge Clock);
    z = zz; run_type = rr; clr = cc; sel = ss;
    rise = zz && (m_prev_z == 0);
    if (cc) begin
      m_n0 = 0; m_n1 = 0; m_best = 0; m_ovf = 1'b0;
      m_active = 0; m_len = 0; m_pulse = 1'b0;
    end else begin
      m_pulse = rise && (m_active == 0);
      if (rise && (m_active == 0)) begin
        m_active = 1;
        m_start  = k;
        m_len    = 1;
        if (rr) begin m_n1++; if (m_n1 % 256 == 0) m_ovf = 1'b1; end
        else    begin m_n0++; if (m_n0 % 256 == 0) m_ovf = 1'b1; end
      end else if (m_active != 0 && zz) begin
        m_len = min_i(k - m_start + 1, 255);
      end else if (m_active != 0 && !zz) begin
        len = min_i(k - m_start, 255);
        if (len > m_best) m_best = len;
        m_active = 0;
      end
    end
    m_prev_z = zz ? 1 : 0;
    case (ss)
      2'b00:   v = m_n0 % 256;
      2'b01:   v = m_n1 % 256;
      2'b10:   v = m_best;
      default: v = m_len;
    endcase
    e.c0 = 8'(m_n0 % 256);
    e.c1 = 8'(m_n1 % 256);
    e.mx = 8'(m_best);
    e.pulse = m_pulse;
    e.ovf = m_ovf;
    e.h1 = glyph(v / 16);
    e.h0 = glyph(v % 16);
    sb_q.push_back(e);
    k++;
  endtask

  always @(posedge Clock) begin : monitor
    exp_t e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("count0", 32'(count0), 32'(e.c0));
      check("count1", 32'(count1), 32'(e.c1));
      check("max_run", 32'(max_run), 32'(e.mx));
      check("match_pulse", 32'(match_pulse), 32'(e.pulse));
      check("ovf", 32'(ovf), 32'(e.ovf));
      check("HEX1", 32'(HEX1), 32'(e.h1));
      check("HEX0", 32'(HEX0), 32'(e.h0));
    end
  end

  always @(posedge Clock) begin
    #1;
    if (match_pulse === 1'b1) pulse_cnt++;
  end

  // Directed checks run just after an edge, once the monitor has sampled.
  task automatic settle();
    @(posedge Clock);
    #3;
  endtask

  task automatic run(input int len, input logic rr, input logic [1:0] ss);
    for (int i = 0; i < len; i++) step(1'b1, rr, 1'b0, ss);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; z = 1'b0; run_type = 1'b0; clr = 1'b0; sel = 2'b10;
    model_reset();
    repeat (2) @(negedge Clock);
    check("reset count0", 32'(count0), 0);
    check("reset count1", 32'(count1), 0);
    check("reset max_run", 32'(max_run), 0);
    check("reset ovf", 32'(ovf), 0);
    check("reset HEX1", 32'(HEX1), 32'h40);
    check("reset HEX0", 32'(HEX0), 32'h40);
    reset_n = 1'b1;

    // Single ones-run of four cycles.
    step(1'b0, 1'b0, 1'b0, 2'b10);
    pulse_cnt = 0;
    run(4, 1'b1, 2'b10);
    step(1'b0, 1'b1, 1'b0, 2'b10);
    step(1'b0, 1'b1, 1'b0, 2'b01);
    settle();
    check("s1 count1", 32'(count1), 1);
    check("s1 count0", 32'(count0), 0);
    check("s1 max_run", 32'(max_run), 4);
    check("s1 pulses", 32'(pulse_cnt), 1);

    // Two zeros-runs of 3 and 6, one idle cycle apart.
    step(1'b0, 1'b0, 1'b1, 2'b00);
    settle();
    pulse_cnt = 0;
    run(3, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    run(6, 1'b0, 2'b11);
    step(1'b0, 1'b0, 1'b0, 2'b10);
    settle();
    check("s2 count0", 32'(count0), 2);
    check("s2 max_run", 32'(max_run), 6);
    check("s2 pulses", 32'(pulse_cnt), 2);

    // Wrap count0 and observe the sticky overflow.
    step(1'b0, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 255; i++) begin
      step(1'b1, 1'b0, 1'b0, 2'b00);
      step(1'b0, 1'b0, 1'b0, 2'b00);
    end
    settle();
    check("s3 count0 full", 32'(count0), 255);
    check("s3 ovf before", 32'(ovf), 0);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    settle();
    check("s3 count0 wrap", 32'(count0), 0);
    check("s3 ovf set", 32'(ovf), 1);
    step(1'b0, 1'b0, 1'b1, 2'b00);
    settle();
    check("s3 ovf clr", 32'(ovf), 0);

    // Long run saturates run_len.
    run(300, 1'b1, 2'b11);
    settle();
    check("s4 run_len HEX1", 32'(HEX1), 32'h0E);
    check("s4 run_len HEX0", 32'(HEX0), 32'h0E);
    step(1'b0, 1'b1, 1'b0, 2'b10);
    settle();
    check("s4 max_run", 32'(max_run), 255);

    // clr coinciding with rise: z stays high but no match is recognised.
    step(1'b0, 1'b1, 1'b1, 2'b11);
    settle();
    pulse_cnt = 0;
    step(1'b1, 1'b1, 1'b1, 2'b11);
    run(4, 1'b1, 2'b11);
    settle();
    check("s5 count1", 32'(count1), 0);
    check("s5 pulses", 32'(pulse_cnt), 0);
    check("s5 run_len HEX0", 32'(HEX0), 32'h40);
    check("s5 max_run", 32'(max_run), 0);
    step(1'b0, 1'b0, 1'b0, 2'b10);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 2000; i++) begin
      logic zz;
      zz = (m_prev_z != 0) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      step(zz, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0),
           2'($urandom_range(0, 3)));
    end
    step(1'b0, 1'b0, 1'b0, 2'b10);

    // Asynchronous reset in the middle of a run.
    step(1'b0, 1'b0, 1'b1, 2'b10);
    run(3, 1'b0, 2'b10);
    step(1'b0, 1'b0, 1'b0, 2'b10);
    run(10, 1'b1, 2'b10);
    @(negedge Clock);
    #2;
    reset_n = 1'b0;
    z = 1'b0;
    #1;
    check("async count0", 32'(count0), 0);
    check("async count1", 32'(count1), 0);
    check("async max_run", 32'(max_run), 0);
    check("async match_pulse", 32'(match_pulse), 0);
    check("async ovf", 32'(ovf), 0);
    check("async HEX1", 32'(HEX1), 32'h40);
    check("async HEX0", 32'(HEX0), 32'h40);
    model_reset();
    @(negedge Clock);
    reset_n = 1'b1;
    pulse_cnt = 0;
    run(5, 1'b1, 2'b01);
    step(1'b0, 1'b1, 1'b0, 2'b10);
    settle();
    check("post-reset count1", 32'(count1), 1);
    check("post-reset max_run", 32'(max_run), 5);
    check("post-reset pulses", 32'(pulse_cnt), 1);

    repeat (2) @(negedge Clock);
    check("scoreboard drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
